jump_redirect_gen: RTL and testbench
====================================

# jump_redirect_gen

Consumer side of the jump unit's writeback: takes each resolved jump/auipc result, compares the computed target against the frontend's predicted target, and generates a registered, oldest-first redirect request toward the frontend/ROB. It sits between the jump execution unit's writeback port and the backend redirect arbiter. Its job is to buffer one redirect, honour flushes, and hold the request until the redirect consumer accepts it.

## Interface
- ROB_IDX_W, default 8: width of ROB index value field; a separate flag bit is added for wrap-around.
- VADDR_W, default 64: width of PC and target.
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_in_valid  in  1  jump-unit writeback valid; no backpressure, always accepted
- io_in_robIdx_flag  in  1  ROB wrap flag
- io_in_robIdx_value  in  ROB_IDX_W  ROB index
- io_in_pc  in  VADDR_W  instruction PC
- io_in_target  in  VADDR_W  computed jump target (bit 0 already zero)
- io_in_predTarget  in  VADDR_W  frontend-predicted target
- io_in_predTaken  in  1  frontend predicted taken
- io_in_isAuipc  in  1  auipc op; never mispredicts
- io_flush_valid  in  1  backend flush
- io_flush_robIdx_flag / io_flush_robIdx_value  in  1 / ROB_IDX_W  flush point
- io_redirect_ready  in  1  consumer accepts redirect
- io_redirect_valid  out  1  redirect pending
- io_redirect_robIdx_flag / io_redirect_robIdx_value  out  1 / ROB_IDX_W
- io_redirect_pc  out  VADDR_W  PC of mispredicted jump
- io_redirect_target  out  VADDR_W  correct fetch target

## Operation
- Age: A is older than B iff (A.flag == B.flag) ? A.value < B.value : A.value > B.value. Equal indices are not older.
- Stage 1 (s1) registers the input when io_in_valid is high and the input is not killed.
- Mispredict (computed on s1): !isAuipc && (!predTaken || target != predTarget), using a full VADDR_W compare.
- Redirect register (r): loads s1 when s1 is a mispredict and any one of the following holds:
  - r is empty;
  - r fires this cycle (valid && ready);
  - s1 is older than r.
  - Otherwise s1 is dropped, so the oldest redirect wins.
- Clearing r: on io_redirect_valid && io_redirect_ready, unless it reloads in the same cycle.
- Flush kill: any entry (input, s1, r) whose robIdx is strictly younger than the flush robIdx is invalidated in the flush cycle. The entry at the flush index itself survives.
- Flush takes priority over both load and hold. A killed r does not fire, even when ready is high.
- Outputs come straight from the r register with no combinational path from inputs. Data fields hold their last value when valid is low.

## Timing
- Input at cycle T → s1 at T+1 → io_redirect_valid at T+2 at the earliest.
- Throughput: one input per cycle. At most one redirect is buffered.
- Reset clears s1_valid, r_valid and all r fields to 0, so every output is 0 the cycle after reset is asserted.
- Reset asserted mid-hold discards the pending redirect; no handshake is required.
- io_redirect_valid, once high, stays high with stable fields until accepted, flushed, or replaced by an older mispredict. A replacement updates all fields in the same cycle.

## Configuration
- JUMP_REDIRECT_PERF_EN defined:
  - adds outputs io_perf_mispredCnt (32 bits, counts s1 mispredicts) and io_perf_dropCnt (32 bits, counts mispredicts dropped by age or flush);
  - both counters reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent. Functional behaviour is identical either way.

## Test plan
- Single jump, pc=0x8000_0000, target=0x8000_0100, predTarget=0x8000_0100, predTaken=1 → no redirect ever. With predTarget=0x8000_0200 instead → io_redirect_valid at T+2 with target 0x8000_0100.
- auipc with mismatching predTarget → no redirect.
- Mispredict robIdx (0,10) held with ready=0, then mispredict (0,5) → r replaced by (0,5). Then mispredict (0,20) → dropped (dropCnt=1 with PERF_EN).
- Age across wrap: pending (1,3), then mispredict (0,250) → (0,250) is older and replaces it.
- Flush at (0,7) while r=(0,9) and s1=(0,6) → r killed, s1 survives → redirect (0,6) next cycle. A flush at exactly (0,9) keeps r.
- Accept and load in the same cycle: ready=1 on r=(0,4) while s1 mispredict (0,8) → (0,4) fires, (0,8) is valid the next cycle without a gap.

Source files
------------

// File: rtl/jump_redirect_gen.sv
// jump_redirect_gen: jump-unit writeback consumer. Registers each resolved
// jump (s1 stage), detects target mispredicts and keeps the oldest pending
// redirect in a single holding register until the consumer accepts it,
// a flush kills it, or an older mispredict replaces it.
// Optional build macro JUMP_REDIRECT_PERF_EN adds saturating mispredict and
// drop counters on io_perf_mispredCnt / io_perf_dropCnt.
module jump_redirect_gen #(
  parameter int ROB_IDX_W = 8,
  parameter int VADDR_W   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  input  logic                 io_in_robIdx_flag,
  input  logic [ROB_IDX_W-1:0] io_in_robIdx_value,
  input  logic [VADDR_W-1:0]   io_in_pc,
  input  logic [VADDR_W-1:0]   io_in_target,
  input  logic [VADDR_W-1:0]   io_in_predTarget,
  input  logic                 io_in_predTaken,
  input  logic                 io_in_isAuipc,
  input  logic                 io_flush_valid,
  input  logic                 io_flush_robIdx_flag,
  input  logic [ROB_IDX_W-1:0] io_flush_robIdx_value,
  input  logic                 io_redirect_ready,
  output logic                 io_redirect_valid,
  output logic                 io_redirect_robIdx_flag,
  output logic [ROB_IDX_W-1:0] io_redirect_robIdx_value,
  output logic [VADDR_W-1:0]   io_redirect_pc,
  output logic [VADDR_W-1:0]   io_redirect_target
`ifdef JUMP_REDIRECT_PERF_EN
  ,
  output logic [31:0]          io_perf_mispredCnt,
  output logic [31:0]          io_perf_dropCnt
`endif
);

  // A is older than B; equal indices are not older. The flag flips on every
  // ROB wrap, so differing flags invert the value comparison.
  function automatic logic is_older(input logic a_flag, input logic [ROB_IDX_W-1:0] a_val,
                                    input logic b_flag, input logic [ROB_IDX_W-1:0] b_val);
    return (a_flag == b_flag) ? (a_val < b_val) : (a_val > b_val);
  endfunction

  // Saturating 32-bit increment for the performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // s1 stage registers
  logic                 vld_p1;
  logic                 flag_p1;
  logic [ROB_IDX_W-1:0] value_p1;
  logic [VADDR_W-1:0]   pc_p1;
  logic [VADDR_W-1:0]   target_p1;
  logic [VADDR_W-1:0]   pred_target_p1;
  logic                 pred_taken_p1;
  logic                 is_auipc_p1;

  // redirect holding register
  logic                 vld_p2;
  logic                 flag_p2;
  logic [ROB_IDX_W-1:0] value_p2;
  logic [VADDR_W-1:0]   pc_p2;
  logic [VADDR_W-1:0]   target_p2;

  logic kill_in;
  logic kill_p1;
  logic kill_p2;
  logic mispred_raw_p1;
  logic mispred_p1;
  logic live_p2;
  logic fire_p2;
  logic load_p2;

  // Flush kill, mispredict detection and the load/hold/clear decision.
  always_comb begin
    kill_in        = io_flush_valid && is_older(io_flush_robIdx_flag, io_flush_robIdx_value,
                                                io_in_robIdx_flag, io_in_robIdx_value);
    kill_p1        = io_flush_valid && is_older(io_flush_robIdx_flag, io_flush_robIdx_value,
                                                flag_p1, value_p1);
    kill_p2        = io_flush_valid && is_older(io_flush_robIdx_flag, io_flush_robIdx_value,
                                                flag_p2, value_p2);
    mispred_raw_p1 = vld_p1 && !is_auipc_p1 &&
                     (!pred_taken_p1 || (target_p1 != pred_target_p1));
    mispred_p1     = mispred_raw_p1 && !kill_p1;
    // A flushed entry neither fires nor blocks a newer load.
    live_p2        = vld_p2 && !kill_p2;
    fire_p2        = live_p2 && io_redirect_ready;
    load_p2        = mispred_p1 &&
                     (!live_p2 || fire_p2 || is_older(flag_p1, value_p1, flag_p2, value_p2));
  end

  // ---- stage boundary: input -> s1 ----
  // s1 valid tracks accepted, non-flushed writebacks.
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= io_in_valid && !kill_in;
  end

  // s1 payload captured on every valid writeback; qualified by vld_p1.
  always_ff @(posedge clock) begin
    if (io_in_valid) begin
      flag_p1        <= io_in_robIdx_flag;
      value_p1       <= io_in_robIdx_value;
      pc_p1          <= io_in_pc;
      target_p1      <= io_in_target;
      pred_target_p1 <= io_in_predTarget;
      pred_taken_p1  <= io_in_predTaken;
      is_auipc_p1    <= io_in_isAuipc;
    end
  end

  // ---- stage boundary: s1 -> redirect register ----
  // Redirect register: load oldest mispredict, hold until fired or killed.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      flag_p2   <= 1'b0;
      value_p2  <= '0;
      pc_p2     <= '0;
      target_p2 <= '0;
    end else begin
      vld_p2 <= load_p2 || (live_p2 && !fire_p2);
      if (load_p2) begin
        flag_p2   <= flag_p1;
        value_p2  <= value_p1;
        pc_p2     <= pc_p1;
        target_p2 <= target_p1;
      end
    end
  end

  assign io_redirect_valid        = vld_p2;
  assign io_redirect_robIdx_flag  = flag_p2;
  assign io_redirect_robIdx_value = value_p2;
  assign io_redirect_pc           = pc_p2;
  assign io_redirect_target       = target_p2;

`ifdef JUMP_REDIRECT_PERF_EN
  logic [31:0] mispred_cnt;
  logic [31:0] drop_cnt;

  // Count every s1 mispredict, and those lost to age arbitration or flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      mispred_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (mispred_raw_p1)             mispred_cnt <= sat_inc(mispred_cnt);
      if (mispred_raw_p1 && !load_p2) drop_cnt    <= sat_inc(drop_cnt);
    end
  end

  assign io_perf_mispredCnt = mispred_cnt;
  assign io_perf_dropCnt    = drop_cnt;
`endif

endmodule

// File: tb/tb_jump_redirect_gen.sv
// Self-checking bench for jump_redirect_gen: directed scenarios push the
// redirects expected to be accepted into a scoreboard; a negedge monitor pops
// and compares on every handshake.
module tb_jump_redirect_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_in_robIdx_flag = 1'b0;
  logic [7:0]  io_in_robIdx_value = '0;
  logic [63:0] io_in_pc = '0;
  logic [63:0] io_in_target = '0;
  logic [63:0] io_in_predTarget = '0;
  logic        io_in_predTaken = 1'b0;
  logic        io_in_isAuipc = 1'b0;
  logic        io_flush_valid = 1'b0;
  logic        io_flush_robIdx_flag = 1'b0;
  logic [7:0]  io_flush_robIdx_value = '0;
  logic        io_redirect_ready = 1'b0;
  logic        io_redirect_valid;
  logic        io_redirect_robIdx_flag;
  logic [7:0]  io_redirect_robIdx_value;
  logic [63:0] io_redirect_pc;
  logic [63:0] io_redirect_target;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        f;
    logic [7:0]  v;
    logic [63:0] pc;
    logic [63:0] tgt;
  } exp_t;
  exp_t sb[$];

  jump_redirect_gen #(.ROB_IDX_W(8), .VADDR_W(64)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_in_valid              (io_in_valid),
    .io_in_robIdx_flag        (io_in_robIdx_flag),
    .io_in_robIdx_value       (io_in_robIdx_value),
    .io_in_pc                 (io_in_pc),
    .io_in_target             (io_in_target),
    .io_in_predTarget         (io_in_predTarget),
    .io_in_predTaken          (io_in_predTaken),
    .io_in_isAuipc            (io_in_isAuipc),
    .io_flush_valid           (io_flush_valid),
    .io_flush_robIdx_flag     (io_flush_robIdx_flag),
    .io_flush_robIdx_value    (io_flush_robIdx_value),
    .io_redirect_ready        (io_redirect_ready),
    .io_redirect_valid        (io_redirect_valid),
    .io_redirect_robIdx_flag  (io_redirect_robIdx_flag),
    .io_redirect_robIdx_value (io_redirect_robIdx_value),
    .io_redirect_pc           (io_redirect_pc),
    .io_redirect_target       (io_redirect_target)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pc_of(input logic f, input int v);
    return 64'h8000_0000 + {55'd0, f, v[7:0]} * 64'd4;
  endfunction

  function automatic logic [63:0] tgt_of(input logic f, input int v);
    return 64'h9000_0000 + {55'd0, f, v[7:0]} * 64'd16;
  endfunction

  // Drive one writeback; returns 1ns after the edge that captured it into s1.
  task automatic send(input logic f, input int v, input bit mis, input bit auipc, input bit taken);
    @(posedge clock); #1;
    io_in_valid        = 1'b1;
    io_in_robIdx_flag  = f;
    io_in_robIdx_value = v[7:0];
    io_in_pc           = pc_of(f, v);
    io_in_target       = tgt_of(f, v);
    io_in_predTarget   = mis ? tgt_of(f, v) + 64'h100 : tgt_of(f, v);
    io_in_predTaken    = taken;
    io_in_isAuipc      = auipc;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic f, input int v);
    exp_t e;
    e.f = f; e.v = v[7:0]; e.pc = pc_of(f, v); e.tgt = tgt_of(f, v);
    sb.push_back(e);
  endtask

  // Hold ready high for one cycle; the monitor pops the matching entry.
  task automatic accept(input logic f, input int v);
    push_exp(f, v);
    @(posedge clock); #1 io_redirect_ready = 1'b1;
    @(posedge clock); #1 io_redirect_ready = 1'b0;
  endtask

  task automatic flush_at(input logic f, input int v);
    @(posedge clock); #1;
    io_flush_valid = 1'b1; io_flush_robIdx_flag = f; io_flush_robIdx_value = v[7:0];
    @(posedge clock); #1 io_flush_valid = 1'b0;
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sample at the next negedge and compare the redirect outputs.
  task automatic expect_r(input string tag, input bit vld, input logic f, input int v);
    @(negedge clock);
    check_eq({tag, "_valid"}, {63'd0, io_redirect_valid}, {63'd0, vld});
    if (vld) begin
      check_eq({tag, "_idx"}, {55'd0, io_redirect_robIdx_flag, io_redirect_robIdx_value},
               {55'd0, f, v[7:0]});
      check_eq({tag, "_target"}, io_redirect_target, tgt_of(f, v));
    end
  endtask

  task automatic expect_zero(input string tag);
    @(negedge clock);
    check_eq({tag, "_valid"}, {63'd0, io_redirect_valid}, 64'd0);
    check_eq({tag, "_idx"}, {55'd0, io_redirect_robIdx_flag, io_redirect_robIdx_value}, 64'd0);
    check_eq({tag, "_pc"}, io_redirect_pc, 64'd0);
    check_eq({tag, "_target"}, io_redirect_target, 64'd0);
  endtask

  // Scoreboard monitor: every handshake must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && io_redirect_valid && io_redirect_ready) begin
      check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("fire_idx", {55'd0, io_redirect_robIdx_flag, io_redirect_robIdx_value},
                 {55'd0, e.f, e.v});
        check_eq("fire_pc", io_redirect_pc, e.pc);
        check_eq("fire_target", io_redirect_target, e.tgt);
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(posedge clock);
    expect_zero("reset");
    @(posedge clock); #1 reset = 1'b0;

    // correct prediction: never redirects
    send(1'b0, 1, 1'b0, 1'b0, 1'b1);
    repeat (3) expect_r("hit", 1'b0, 1'b0, 0);

    // mispredicted target: visible at T+2, not T+1
    send(1'b0, 2, 1'b1, 1'b0, 1'b1);
    expect_r("mis_t1", 1'b0, 1'b0, 0);
    expect_r("mis_t2", 1'b1, 1'b0, 2);
    accept(1'b0, 2);
    expect_r("mis_cleared", 1'b0, 1'b0, 0);

    // auipc with mismatching prediction never redirects
    send(1'b0, 3, 1'b1, 1'b1, 1'b1);
    repeat (3) expect_r("auipc", 1'b0, 1'b0, 0);

    // predicted not-taken with matching target is still a mispredict
    send(1'b0, 11, 1'b0, 1'b0, 1'b0);
    skip(1);
    expect_r("nottaken", 1'b1, 1'b0, 11);
    accept(1'b0, 11);

    // held redirect replaced by an older one, younger one dropped
    send(1'b0, 10, 1'b1, 1'b0, 1'b1);
    skip(1);
    expect_r("hold10", 1'b1, 1'b0, 10);
    send(1'b0, 5, 1'b1, 1'b0, 1'b1);
    expect_r("hold10_stable", 1'b1, 1'b0, 10);
    expect_r("replace5", 1'b1, 1'b0, 5);
    send(1'b0, 20, 1'b1, 1'b0, 1'b1);
    skip(1);
    expect_r("drop20", 1'b1, 1'b0, 5);
    accept(1'b0, 5);
    expect_r("after5", 1'b0, 1'b0, 0);

    // age across wrap: (0,250) is older than (1,3)
    send(1'b1, 3, 1'b1, 1'b0, 1'b1);
    skip(1);
    expect_r("wrap13", 1'b1, 1'b1, 3);
    send(1'b0, 250, 1'b1, 1'b0, 1'b1);
    skip(1);
    expect_r("wrap250", 1'b1, 1'b0, 250);
    accept(1'b0, 250);

    // flush (0,7): r=(0,9) killed, s1=(0,6) survives and loads
    send(1'b0, 9, 1'b1, 1'b0, 1'b1);
    skip(1);
    expect_r("fl_r9", 1'b1, 1'b0, 9);
    send(1'b0, 6, 1'b1, 1'b0, 1'b1);
    io_flush_valid = 1'b1; io_flush_robIdx_flag = 1'b0; io_flush_robIdx_value = 8'd7;
    @(posedge clock); #1 io_flush_valid = 1'b0;
    expect_r("fl_s1_6", 1'b1, 1'b0, 6);
    accept(1'b0, 6);

    // flush of a younger r alone empties it; flush at its own index keeps it
    send(1'b0, 9, 1'b1, 1'b0, 1'b1);
    skip(1);
    flush_at(1'b0, 9);
    expect_r("fl_exact", 1'b1, 1'b0, 9);
    flush_at(1'b0, 7);
    expect_r("fl_kill", 1'b0, 1'b0, 0);

    // flush kills a younger input in the same cycle
    @(posedge clock); #1;
    io_in_valid = 1'b1; io_in_robIdx_flag = 1'b0; io_in_robIdx_value = 8'd12;
    io_in_pc = pc_of(1'b0, 12); io_in_target = tgt_of(1'b0, 12);
    io_in_predTarget = tgt_of(1'b0, 12) + 64'h100; io_in_predTaken = 1'b1; io_in_isAuipc = 1'b0;
    io_flush_valid = 1'b1; io_flush_robIdx_value = 8'd7;
    @(posedge clock); #1 io_in_valid = 1'b0; io_flush_valid = 1'b0;
    repeat (2) expect_r("fl_input", 1'b0, 1'b0, 0);

    // accept and load in the same cycle: no gap
    send(1'b0, 4, 1'b1, 1'b0, 1'b1);
    skip(1);
    send(1'b0, 8, 1'b1, 1'b0, 1'b1);
    push_exp(1'b0, 4);
    io_redirect_ready = 1'b1;
    @(posedge clock); #1 io_redirect_ready = 1'b0;
    expect_r("nogap8", 1'b1, 1'b0, 8);
    accept(1'b0, 8);

    // back-to-back inputs: the older first one wins
    @(posedge clock); #1;
    io_in_valid = 1'b1; io_in_robIdx_value = 8'd40;
    io_in_pc = pc_of(1'b0, 40); io_in_target = tgt_of(1'b0, 40);
    io_in_predTarget = 64'h0; io_in_predTaken = 1'b1; io_in_isAuipc = 1'b0;
    @(posedge clock); #1;
    io_in_robIdx_value = 8'd41; io_in_pc = pc_of(1'b0, 41); io_in_target = tgt_of(1'b0, 41);
    @(posedge clock); #1 io_in_valid = 1'b0;
    expect_r("b2b40", 1'b1, 1'b0, 40);
    accept(1'b0, 40);
    expect_r("b2b_done", 1'b0, 1'b0, 0);

    // reset mid-hold discards the pending redirect
    send(1'b0, 30, 1'b1, 1'b0, 1'b1);
    skip(1);
    expect_r("pre_rst", 1'b1, 1'b0, 30);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    expect_zero("mid_rst");

    repeat (3) @(posedge clock);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
